// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data cache: default geometry,
// FSM state encoding and address-field extraction helpers.
package dcache_pkg;

    localparam int LINE_ADDR_LEN_DEF = 3;
    localparam int SET_ADDR_LEN_DEF  = 4;

    // Cache controller states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WB   = 2'd1;
    localparam state_t ST_FILL = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Word index within the line (right-aligned, caller truncates)
    function automatic logic [31:0] addr_word(input logic [31:0] a, input int line_len);
        return (a >> 2) & ((32'd1 << line_len) - 32'd1);
    endfunction

    // Set index (right-aligned, caller truncates)
    function automatic logic [31:0] addr_set(input logic [31:0] a, input int line_len,
                                             input int set_len);
        return (a >> (2 + line_len)) & ((32'd1 << set_len) - 32'd1);
    endfunction

    // Tag (right-aligned, caller truncates)
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int line_len,
                                             input int set_len);
        return a >> (2 + line_len + set_len);
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Word-serial request/acknowledge bus between the cache and main memory.
// master = cache side, slave = memory side.
interface dcache_wb_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dcache_line_ram.sv
// Storage for the direct-mapped cache: per-byte writable data array with a
// combinational read port, plus tag/valid/dirty arrays indexed by set.
module dcache_line_ram #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_ADDR_LEN  = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SET_ADDR_LEN-1:0]  set,
    input  logic [LINE_ADDR_LEN-1:0] rd_word,
    output logic [31:0]              rd_data,
    output logic                     line_valid,
    output logic                     line_dirty,
    output logic [TAG_ADDR_LEN-1:0]  line_tag,
    input  logic                     wr_en,
    input  logic [LINE_ADDR_LEN-1:0] wr_word,
    input  logic [3:0]               wr_be,
    input  logic [31:0]              wr_data,
    input  logic                     meta_we,
    input  logic                     meta_valid,
    input  logic                     meta_dirty,
    input  logic [TAG_ADDR_LEN-1:0]  meta_tag
);
    localparam int WORDS = 1 << (LINE_ADDR_LEN + SET_ADDR_LEN);
    localparam int NSETS = 1 << SET_ADDR_LEN;

    logic [31:0]             data_q [WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_q  [NSETS];
    logic [NSETS-1:0]        valid_q;
    logic [NSETS-1:0]        dirty_q;

    assign rd_data    = data_q[{set, rd_word}];
    assign line_valid = valid_q[set];
    assign line_dirty = dirty_q[set];
    assign line_tag   = tag_q[set];

    // Byte-masked data write (store hit or fill word)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_q[{set, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Tag update; contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (meta_we) tag_q[set] <= meta_tag;
    end

    // Valid/dirty state, cleared by reset so the whole cache is cold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[set] <= meta_valid;
            dirty_q[set] <= meta_dirty;
        end
    end
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional build macro DCACHE_STATS_EN adds hit_count/miss_count outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | serve hits; a miss picks WB (dirty victim) or FILL
// WB      | write victim words 0..N-1 to memory, one per ack
// FILL    | read new line words 0..N-1 from memory, one per ack
// DONE    | one bubble cycle with miss held, then replay in IDLE
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    dcache_wb_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;

    state_t                   state;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [LINE_ADDR_LEN-1:0] word;
    logic [SET_ADDR_LEN-1:0]  set;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic [31:0]              ram_rd_data;
    logic                     line_valid, line_dirty;
    logic [TAG_ADDR_LEN-1:0]  line_tag;
    logic                     idle, in_wb, in_fill, access, hit, ack_ok, last, store_hit;

    assign word = LINE_ADDR_LEN'(addr_word(addr, LINE_ADDR_LEN));
    assign set  = SET_ADDR_LEN'(addr_set(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign tag  = TAG_ADDR_LEN'(addr_tag(addr, LINE_ADDR_LEN, SET_ADDR_LEN));

    assign idle      = (state == ST_IDLE);
    assign in_wb     = (state == ST_WB);
    assign in_fill   = (state == ST_FILL);
    assign access    = rd_req | wr_req;
    assign hit       = line_valid & (line_tag == tag);
    assign ack_ok    = mem.ack & mem.req;
    assign last      = &cnt;
    assign store_hit = idle & wr_req & hit;

    // Core-side outputs; rd_data is forced to zero outside a read hit
    assign miss    = idle ? (access & ~hit) : 1'b1;
    assign rd_data = (idle & rd_req & ~wr_req & hit) ? ram_rd_data : 32'd0;

    // Memory bus: victim address uses the stored tag, fill uses the request tag
    assign mem.req   = in_wb | in_fill;
    assign mem.we    = in_wb;
    assign mem.addr  = in_wb   ? {line_tag, set, cnt, 2'b00} :
                       in_fill ? {tag, set, cnt, 2'b00} : 32'd0;
    assign mem.wdata = in_wb ? ram_rd_data : 32'd0;

    dcache_line_ram #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .SET_ADDR_LEN (SET_ADDR_LEN),
        .TAG_ADDR_LEN (TAG_ADDR_LEN)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (set),
        .rd_word   (in_wb ? cnt : word),
        .rd_data   (ram_rd_data),
        .line_valid(line_valid),
        .line_dirty(line_dirty),
        .line_tag  (line_tag),
        .wr_en     (store_hit | (in_fill & ack_ok)),
        .wr_word   (in_fill ? cnt : word),
        .wr_be     (in_fill ? 4'hF : wr_be),
        .wr_data   (in_fill ? mem.rdata : wr_data),
        .meta_we   (store_hit | (in_fill & ack_ok & last)),
        .meta_valid(1'b1),
        .meta_dirty(idle),
        .meta_tag  (tag)
    );

    // Miss sequencing; the word counter wraps to 0 after the last ack of each phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access & ~hit) state <= (line_valid & line_dirty) ? ST_WB : ST_FILL;
                end
                ST_WB: begin
                    if (ack_ok) begin
                        cnt <= cnt + 1'b1;
                        if (last) state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (ack_ok) begin
                        cnt <= cnt + 1'b1;
                        if (last) state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit counts every access completing in IDLE; miss counts each line swap started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (idle & access) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
